// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Receives 8N1 serial frames (LSB first) from an asynchronous line. Each
// correctly framed byte appears on dout with a one-cycle dout_valid strobe.
// A frame whose stop bit samples low gives a one-cycle frame_err strobe and
// leaves dout alone.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   rx_p       serial input, asynchronous to clk, idle high
//   dout       last correctly received byte (held until the next good frame)
//   dout_valid one-cycle pulse on the edge that updates dout
//   frame_err  one-cycle pulse when the stop bit samples low
//   rx_busy    high whenever the receiver is not idle
//
// Output contract: dout_valid and frame_err are plain strobes with no
// back-pressure. The consumer must take dout on the cycle dout_valid is high,
// or at any point before the next strobe, which is at least one frame time
// (10 * BIT_CNT cycles) later.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int clk_freq  = 50_000_000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_p,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT  = clk_freq / uart_freq;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT) + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s2_prev_q, s2_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitpos_q, bitpos_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    // Synchronizer chain; s2_prev only exists to detect the falling edge.
    s1_d         = rx_p;
    s2_d         = s1_q;
    s2_prev_d    = s2_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    bitpos_d     = bitpos_q;
    sh_d         = sh_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a line stuck low after a
        // break cannot keep retriggering.
        if (s2_prev_q && !s2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!s2_q) begin
            state_d  = DATA;
            bitpos_d = 3'd0;
          end else begin
            // Line already back high at mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        // Counting a full bit from mid start bit lands each sample mid-bit.
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          sh_d[bitpos_q] = s2_q;
          if (bitpos_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitpos_d = bitpos_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for the next
        // start edge.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (s2_q) begin
            dout_d       = sh_q;
            dout_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s2_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bitpos_q     <= 3'd0;
      sh_q         <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s2_prev_q    <= s2_prev_d;
      cnt_q        <= cnt_d;
      bitpos_q     <= bitpos_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  // Decoded straight from the state register, so it drops on the same edge
  // as the result strobes.
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1 bytes from an asynchronous serial line and presents each byte with a one-cycle valid strobe. It is the receive counterpart of the UART transmitter, uses the same `clk_freq`/`uart_freq` parameters and bit ordering (LSB first), and sits between the board RX pin and the byte-level logic.

## Interface
- `clk_freq`, default 50_000_000: system clock frequency in Hz.
- `uart_freq`, default 115200: baud rate in Hz.
- Derived `BIT_CNT = clk_freq / uart_freq` (integer division; 434 at defaults).
- Derived `HALF_CNT = BIT_CNT / 2` (217 at defaults).
- Counter width is `$clog2(BIT_CNT)+1`.
- Supported parameter range: `BIT_CNT >= 4`.

- `clk`  input  1  system clock; every flop is on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is synchronous and active-low.
- `rx_p`  input  1  serial line, asynchronous to `clk`, idle high.
- `dout`  output  8  last correctly received byte. Holds until the next good frame.
- `dout_valid`  output  1  one-cycle pulse when `dout` is updated.
- `frame_err`  output  1  one-cycle pulse when a stop bit is sampled low.
- `rx_busy`  output  1  high whenever the state is not IDLE.

## Operation
- **Input synchronizer:**
  - Two-flop synchronizer `rx_p -> s1 -> s2`.
  - A third flop `s2_d` holds the previous `s2`.
  - All three reset to 1.
  - All logic below uses `s2`.
- **States:** IDLE, START, DATA, STOP.
  - One bit counter `cnt` (0..BIT_CNT-1).
  - Bit index `bitpos` (0..7).
  - Shift register `sh[7:0]`.
- **IDLE:**
  - On a falling edge (`s2_d==1 && s2==0`): go to START and clear `cnt`.
  - A line that is merely held low (no edge) never starts a frame.
- **START:**
  - `cnt` increments each cycle.
  - When `cnt == HALF_CNT-1`, sample `s2`:
    - 0: go to DATA, clear `cnt` and `bitpos`.
    - 1: glitch. Return to IDLE with no output.
- **DATA:**
  - When `cnt == BIT_CNT-1`: sample `s2` into `sh[bitpos]` and clear `cnt`.
  - If `bitpos==7`, go to STOP; otherwise increment `bitpos`.
  - Each sample therefore lands at mid-bit.
- **STOP:**
  - When `cnt == BIT_CNT-1`, sample `s2`, then go to IDLE.
  - Sample 1: `dout <= sh` and pulse `dout_valid`.
  - Sample 0: pulse `frame_err` and leave `dout` unchanged.
- **Re-arm:**
  - A new frame needs a fresh falling edge seen in IDLE.
  - A break (line held low) after a frame error produces exactly one `frame_err` and nothing more until the line returns high and falls again.
- **Reset** (any time, including mid-frame) forces:
  - state IDLE, `cnt=0`, `bitpos=0`, `sh=0`;
  - `dout=8'h00`, `dout_valid=0`, `frame_err=0`, `rx_busy=0`;
  - synchronizer flops to 1.
- No framing on parity; no FIFO. Downstream must consume `dout` before the next `dout_valid`, at least one frame time (10×BIT_CNT cycles) later.

## Timing
- Synchronizer latency is 2 cycles; edge detect adds 1.
- START sample is taken HALF_CNT cycles after START entry.
- Each data bit is taken BIT_CNT cycles after the previous sample.
- The stop sample is taken BIT_CNT cycles after data bit 7.
- `dout_valid`/`frame_err` therefore assert registered, `3 + HALF_CNT + 9*BIT_CNT` (±1) cycles after the first `clk` edge that sees `rx_p` low.
- `dout` changes on the same edge that `dout_valid` rises. Both are registered outputs.
- `dout_valid` and `frame_err` are mutually exclusive and never exceed 1 cycle.
- `rx_busy` rises the cycle after the edge is detected. It falls on the same edge as `dout_valid`/`frame_err`, or after a glitch rejection.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start edge arriving one full stop bit later is always caught.
- Tolerated baud mismatch is at least ±3% at defaults.

## Test plan
Use `clk_freq=1_000_000` and `uart_freq=100_000` (BIT_CNT=10) unless stated. Drive `rx_p` from a bit-accurate bench model.

1. **Single byte:** after reset release, send 0x55.
   - `dout=0x55` with exactly one `dout_valid` pulse at cycle 3+5+90 (±1) from the start edge.
   - `frame_err` never asserts.
   - `rx_busy` is high throughout the frame.
2. **Pattern bytes:** send 0x00, 0xFF, 0xA5 and 0x01 back-to-back, each with 1 stop bit.
   - Four `dout_valid` pulses with those values, in order.
3. **Glitch rejection:** drive `rx_p` low for 3 cycles (< HALF_CNT), then high.
   - No `dout_valid`, no `frame_err`.
   - `rx_busy` returns low within 6 cycles.
4. **Framing error:** after a good 0x3C, send 0x81 with the stop bit low, then hold low for 30 cycles.
   - Exactly one `frame_err` pulse; `dout` stays 0x3C.
   - After the line returns high, a following 0x7E is received correctly.
5. **Reset mid-frame:** assert `rst_n=0` for 1 cycle during data bit 4 of a frame.
   - Outputs are 0 on the next cycle; the partial frame produces no output.
   - The next full 0xC3 frame yields `dout=0xC3`.
6. **Loopback at defaults (50 MHz/115200):** connect the transmitter output to `rx_p` and send 0x00..0xFF.
   - 256 `dout_valid` pulses whose data match the sent bytes.
   - Zero `frame_err`.
